instr_fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of `exec_unit`. It reads 16-bit instructions as two consecutive bytes from the byte-wide `ram` and assembles them. It buffers complete instructions in a small prefetch queue and hands them to decode/execute over a valid/ready handshake. A redirect port lets the execution stage steer fetch on taken jumps (`JZI`/`JZR`); a redirect flushes all buffered and in-flight work.

---
 rtl/instr_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit (plus its constants_pkg)
//  Purpose  : Instruction fetch stage ahead of exec_unit. Reads 16-bit
//             instructions as two consecutive bytes from the byte-wide ram,
//             assembles them, buffers complete instructions in a small
//             prefetch queue and hands them to decode over valid/ready.
//             A redirect restarts fetch and flushes buffered and in-flight
//             work.
//  Config   : `IFETCH_PREFETCH_EN defined   -> 2-entry prefetch queue
//             `IFETCH_PREFETCH_EN undefined -> single holding register
//  Ports    : clk, reset (async, active-high)
//             fetch_en                     - allow new fetches to start
//             mem_addr / mem_rd_en         - registered ram read request
//             mem_rd_data                  - ram byte, valid 2 edges after req
//             instr / instr_pc / instr_valid / instr_ready - output handshake
//             redirect_valid / redirect_pc - restart fetch at a new address
//  Revision : 1.0 - initial release
// ============================================================================

package constants_pkg;
  localparam int MEMORY_ADDRESS_BITS = 8;
  localparam int MEMORY_DATA_BITS    = 8;
endpackage

module instr_fetch_unit #(
  parameter int ADDR_BITS = constants_pkg::MEMORY_ADDRESS_BITS,
  parameter int DATA_BITS = constants_pkg::MEMORY_DATA_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fetch_en,
  output logic [ADDR_BITS-1:0]   mem_addr,
  output logic                   mem_rd_en,
  input  logic [DATA_BITS-1:0]   mem_rd_data,
  output logic [2*DATA_BITS-1:0] instr,
  output logic [ADDR_BITS-1:0]   instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   redirect_valid,
  input  logic [ADDR_BITS-1:0]   redirect_pc
);

  localparam int INSTR_BITS = 2 * DATA_BITS;
`ifdef IFETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  // Counters must represent 0..DEPTH inclusive.
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0]     c_depth    = CNT_W'(DEPTH);
  localparam logic [ADDR_BITS-1:0] c_addr_one = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] c_addr_two = ADDR_BITS'(2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  state_t                 r_state, w_state_next;
  logic [ADDR_BITS-1:0]   r_pc, w_pc_next;

  // Request being registered this edge
  logic                   w_req_en;
  logic                   w_req_is_hi;
  logic [ADDR_BITS-1:0]   w_req_addr;
  logic                   r_req_is_hi;   // tag travelling with mem_rd_en

  // Response pipeline: a request seen on mem_rd_en moves here one edge later,
  // and its byte is sampled on the edge after that.
  logic                   r_pend_v;
  logic                   r_pend_is_hi;
  logic [ADDR_BITS-1:0]   r_pend_addr;

  // Assembly holding register for the high byte
  logic [DATA_BITS-1:0]   r_hi_byte;
  logic [ADDR_BITS-1:0]   r_hi_pc;

  // Prefetch queue: slot 0 is always the head, pops shift toward slot 0.
  logic [INSTR_BITS-1:0]  r_q_instr [DEPTH];
  logic [ADDR_BITS-1:0]   r_q_pc    [DEPTH];
  logic [INSTR_BITS-1:0]  w_shift_instr [DEPTH];
  logic [ADDR_BITS-1:0]   w_shift_pc    [DEPTH];
  logic [CNT_W-1:0]       r_count;
  logic [CNT_W-1:0]       w_wr_idx;

  // Reservation count = queued entries + instructions in flight. Space is
  // claimed when the high-byte request issues so a push never stalls.
  logic [CNT_W-1:0]       r_resv;
  logic [CNT_W-1:0]       w_resv_freed;
  logic [CNT_W-1:0]       w_resv_base;
  logic                   w_room;
  logic                   w_issue_hi;

  logic                   w_pop;
  logic                   w_push;
  logic [INSTR_BITS-1:0]  w_push_instr;
  logic [ADDR_BITS-1:0]   w_push_pc;

  // --------------------------------------------------------------------------
  // Handshake and queue bookkeeping
  // --------------------------------------------------------------------------
  assign instr_valid  = (r_count != '0);
  assign instr        = r_q_instr[0];
  assign instr_pc     = r_q_pc[0];

  assign w_pop        = instr_valid & instr_ready;
  // A low byte completes an instruction; bytes sampled on a redirect edge
  // belong to the abandoned stream.
  assign w_push       = r_pend_v & ~r_pend_is_hi & ~redirect_valid;
  assign w_push_instr = {r_hi_byte, mem_rd_data};
  assign w_push_pc    = r_hi_pc;

  // A push on the same edge as a pop lands one slot lower.
  assign w_wr_idx     = r_count - CNT_W'(w_pop);

  // Slot popped this edge counts as already freed.
  assign w_resv_freed = r_resv - CNT_W'(w_pop);
  assign w_room       = fetch_en & (w_resv_freed < c_depth);
  assign w_issue_hi   = w_req_en & w_req_is_hi;
  assign w_resv_base  = redirect_valid ? '0 : w_resv_freed;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    if (gi < DEPTH - 1) begin : g_shift
      assign w_shift_instr[gi] = r_q_instr[gi+1];
      assign w_shift_pc[gi]    = r_q_pc[gi+1];
    end else begin : g_tail
      assign w_shift_instr[gi] = r_q_instr[gi];
      assign w_shift_pc[gi]    = r_q_pc[gi];
    end
  end

  // --------------------------------------------------------------------------
  // Fetch FSM: next state, next pc and the request to register this edge
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_req_en     = 1'b0;
    w_req_is_hi  = 1'b0;
    w_req_addr   = r_pc;

    if (redirect_valid) begin
      // Redirect overrides whatever the FSM was doing.
      w_pc_next = redirect_pc;
      if (fetch_en) begin
        w_req_en     = 1'b1;
        w_req_is_hi  = 1'b1;
        w_req_addr   = redirect_pc;
        w_state_next = HI;
      end else begin
        w_state_next = IDLE;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_room) begin
            w_req_en     = 1'b1;
            w_req_is_hi  = 1'b1;
            w_req_addr   = r_pc;
            w_state_next = HI;
          end
        end
        HI: begin
          // Low byte always follows, even if fetch_en has dropped.
          w_req_en     = 1'b1;
          w_req_addr   = r_pc + c_addr_one;
          w_state_next = LO;
        end
        LO: begin
          // pc moves past the instruction just requested in either branch so
          // a later start from IDLE fetches the next instruction, not this one.
          w_pc_next = r_pc + c_addr_two;
          if (w_room) begin
            w_req_en     = 1'b1;
            w_req_is_hi  = 1'b1;
            w_req_addr   = r_pc + c_addr_two;
            w_state_next = HI;
          end else begin
            w_state_next = IDLE;
          end
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  // --------------------------------------------------------------------------
  // Memory request register and response pipeline
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rd_en    <= 1'b0;
      mem_addr     <= '0;
      r_req_is_hi  <= 1'b0;
      r_pend_v     <= 1'b0;
      r_pend_is_hi <= 1'b0;
      r_pend_addr  <= '0;
      r_hi_byte    <= '0;
      r_hi_pc      <= '0;
    end else begin
      mem_rd_en   <= w_req_en;
      r_req_is_hi <= w_req_is_hi;
      if (w_req_en) begin
        mem_addr <= w_req_addr;
      end

      // A request outstanding at a redirect never reaches the sampling stage.
      r_pend_v     <= mem_rd_en & ~redirect_valid;
      r_pend_is_hi <= r_req_is_hi;
      r_pend_addr  <= mem_addr;

      if (r_pend_v && r_pend_is_hi && !redirect_valid) begin
        r_hi_byte <= mem_rd_data;
        r_hi_pc   <= r_pend_addr;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Queue storage, occupancy and reservation counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_resv  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_instr[i] <= '0;
        r_q_pc[i]    <= '0;
      end
    end else begin
      r_resv <= w_resv_base + CNT_W'(w_issue_hi);

      if (redirect_valid) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end

      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (w_wr_idx == CNT_W'(i))) begin
          r_q_instr[i] <= w_push_instr;
          r_q_pc[i]    <= w_push_pc;
        end else if (w_pop) begin
          r_q_instr[i] <= w_shift_instr[i];
          r_q_pc[i]    <= w_shift_pc[i];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_unit
//  Purpose  : Self-checking bench for instr_fetch_unit. A byte-wide ram model
//             answers requests two edges later; the expected instruction
//             stream is derived from the ram contents and the current fetch
//             start address (pc, pc+2, ... modulo 256).
//  Config   : honours `IFETCH_PREFETCH_EN to pick the expected queue depth.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  localparam int ADDR_BITS = 8;
  localparam int DATA_BITS = 8;
`ifdef IFETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   fetch_en;
  logic [ADDR_BITS-1:0]   mem_addr;
  logic                   mem_rd_en;
  logic [DATA_BITS-1:0]   mem_rd_data;
  logic [2*DATA_BITS-1:0] instr;
  logic [ADDR_BITS-1:0]   instr_pc;
  logic                   instr_valid;
  logic                   instr_ready;
  logic                   redirect_valid;
  logic [ADDR_BITS-1:0]   redirect_pc;

  int n_cmp;
  int n_fail;

  logic [7:0] mem [256];

  instr_fetch_unit #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .mem_addr       (mem_addr),
    .mem_rd_en      (mem_rd_en),
    .mem_rd_data    (mem_rd_data),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  // Synchronous ram: samples the registered request one edge after it is
  // issued and drives the byte for the following cycle. Junk otherwise.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    else           mem_rd_data <= 8'($urandom);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Instruction the program holds at address a: high byte at a, low at a+1.
  function automatic logic [15:0] exp_instr(input logic [7:0] a);
    logic [7:0] b;
    b = a + 8'd1;
    return {mem[a], mem[b]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b1;
    fetch_en       = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (instr !== 16'h0)     begin n_fail++; $display("FAIL reset_instr: got %h expected 0000", instr); end
    n_cmp++; if (instr_pc !== 8'h0)   begin n_fail++; $display("FAIL reset_instr_pc: got %h expected 00", instr_pc); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    n_cmp++; if (mem_rd_en !== 1'b0)  begin n_fail++; $display("FAIL reset_rd_en: got %b expected 0", mem_rd_en); end
    n_cmp++; if (mem_addr !== 8'h0)   begin n_fail++; $display("FAIL reset_addr: got %h expected 00", mem_addr); end
    reset = 1'b0;
    // fetch_en low: nothing may be requested
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (mem_rd_en !== 1'b0 || instr_valid !== 1'b0) begin
        n_fail++; $display("FAIL idle_no_fetch: got rd_en=%b valid=%b expected 0/0", mem_rd_en, instr_valid);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_basic_fetch();
    int gap;
    do_reset();
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
    fetch_en = 1'b1; instr_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency: valid=%b after edge %0d expected 0", instr_valid, k-1); end
      if (k <= 2) begin
        n_cmp++; if (mem_rd_en !== 1'b1 || mem_addr !== 8'(k-1)) begin
          n_fail++; $display("FAIL basic_req: got rd_en=%b addr=%h expected 1/%h", mem_rd_en, mem_addr, 8'(k-1));
        end
      end
    end
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 16'h1234 || instr_pc !== 8'h00) begin
      n_fail++; $display("FAIL basic_first: got v=%b %h@%h expected 1 1234@00", instr_valid, instr, instr_pc);
    end
    gap = (DEPTH == 2) ? 2 : 4;
    for (int k = 1; k < gap; k++) begin
      @(negedge clk);
      n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_gap: valid=%b expected 0", instr_valid); end
    end
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 16'h5678 || instr_pc !== 8'h02) begin
      n_fail++; $display("FAIL basic_second: got v=%b %h@%h expected 1 5678@02", instr_valid, instr, instr_pc);
    end
    fetch_en = 1'b0; instr_ready = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_backpressure();
    int         reqs;
    int         got;
    logic [7:0] ep;
    do_reset();
    fetch_en = 1'b1; instr_ready = 1'b0;
    reqs = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (mem_rd_en) reqs++;
      if (instr_valid) begin
        n_cmp++; if (instr !== exp_instr(8'h00) || instr_pc !== 8'h00) begin
          n_fail++; $display("FAIL bp_hold: got %h@%h expected %h@00", instr, instr_pc, exp_instr(8'h00));
        end
      end
    end
    n_cmp++; if (reqs != 2 * DEPTH) begin n_fail++; $display("FAIL bp_req_count: got %0d expected %0d", reqs, 2 * DEPTH); end
    n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", instr_valid); end
    instr_ready = 1'b1;
    ep = 8'h00; got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      if (instr_valid) begin
        n_cmp++; if (instr !== exp_instr(ep) || instr_pc !== ep) begin
          n_fail++; $display("FAIL bp_order: got %h@%h expected %h@%h", instr, instr_pc, exp_instr(ep), ep);
        end
        ep = ep + 8'd2; got++;
      end
      @(negedge clk);
    end
    n_cmp++; if (got < 5) begin n_fail++; $display("FAIL bp_timeout: got %0d instructions expected 5", got); end
    fetch_en = 1'b0; instr_ready = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_redirect();
    do_reset();
    mem[8'h40] = 8'hAB; mem[8'h41] = 8'hCD;
    fetch_en = 1'b1; instr_ready = 1'b1;
    repeat (5) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: valid=%b expected 0", instr_valid); end
    n_cmp++; if (mem_rd_en !== 1'b1 || mem_addr !== 8'h40) begin
      n_fail++; $display("FAIL redir_req_hi: got %b/%h expected 1/40", mem_rd_en, mem_addr);
    end
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_stale1: valid=%b expected 0", instr_valid); end
    n_cmp++; if (mem_rd_en !== 1'b1 || mem_addr !== 8'h41) begin
      n_fail++; $display("FAIL redir_req_lo: got %b/%h expected 1/41", mem_rd_en, mem_addr);
    end
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_stale2: valid=%b expected 0", instr_valid); end
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 16'hABCD || instr_pc !== 8'h40) begin
      n_fail++; $display("FAIL redir_first: got v=%b %h@%h expected 1 ABCD@40", instr_valid, instr, instr_pc);
    end
    fetch_en = 1'b0; instr_ready = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_wrap();
    logic found;
    do_reset();
    fetch_en = 1'b1; instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 8'hFF;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_cmp++; if (mem_rd_en !== 1'b1 || mem_addr !== 8'hFF) begin
      n_fail++; $display("FAIL wrap_req_ff: got %b/%h expected 1/ff", mem_rd_en, mem_addr);
    end
    @(negedge clk);
    n_cmp++; if (mem_rd_en !== 1'b1 || mem_addr !== 8'h00) begin
      n_fail++; $display("FAIL wrap_req_00: got %b/%h expected 1/00", mem_rd_en, mem_addr);
    end
    found = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      if (c == 3) begin
        n_cmp++; if (instr_valid !== 1'b1 || instr !== exp_instr(8'hFF) || instr_pc !== 8'hFF) begin
          n_fail++; $display("FAIL wrap_instr: got v=%b %h@%h expected 1 %h@ff", instr_valid, instr, instr_pc, exp_instr(8'hFF));
        end
      end
      if (!found && mem_rd_en) begin
        found = 1'b1;
        n_cmp++; if (mem_addr !== 8'h01) begin n_fail++; $display("FAIL wrap_next: got %h expected 01", mem_addr); end
      end
    end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL wrap_next_timeout: no request seen expected addr 01"); end
    fetch_en = 1'b0; instr_ready = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_simultaneous();
    int got;
    do_reset();
    fetch_en = 1'b1; instr_ready = 1'b0;
    for (int c = 0; c < 10 && !instr_valid; c++) @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL sim_setup: valid=%b expected 1", instr_valid); end
    @(negedge clk);
    // Next edge: pop of the head, push of the second instruction (prefetch
    // build) and a redirect all at once.
    n_cmp++; if (instr !== exp_instr(8'h00) || instr_pc !== 8'h00) begin
      n_fail++; $display("FAIL sim_popped: got %h@%h expected %h@00", instr, instr_pc, exp_instr(8'h00));
    end
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h80;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL sim_empty: valid=%b cycle %0d expected 0", instr_valid, k); end
      @(negedge clk);
    end
    n_cmp++; if (instr_valid !== 1'b1 || instr !== exp_instr(8'h80) || instr_pc !== 8'h80) begin
      n_fail++; $display("FAIL sim_first: got v=%b %h@%h expected 1 %h@80", instr_valid, instr, instr_pc, exp_instr(8'h80));
    end
    got = 0;
    for (int c = 0; c < 8 && got == 0; c++) begin
      @(negedge clk);
      if (instr_valid) begin
        got = 1;
        n_cmp++; if (instr !== exp_instr(8'h82) || instr_pc !== 8'h82) begin
          n_fail++; $display("FAIL sim_second: got %h@%h expected %h@82", instr, instr_pc, exp_instr(8'h82));
        end
      end
    end
    n_cmp++; if (got == 0) begin n_fail++; $display("FAIL sim_second_timeout: no instruction expected pc 82"); end
    fetch_en = 1'b0; instr_ready = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_async_reset();
    int lat;
    do_reset();
    fetch_en = 1'b1; instr_ready = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (instr !== 16'h0 || instr_pc !== 8'h0 || instr_valid !== 1'b0 || mem_rd_en !== 1'b0 || mem_addr !== 8'h0) begin
      n_fail++; $display("FAIL async_reset: got instr=%h pc=%h v=%b rd=%b addr=%h expected all 0",
                         instr, instr_pc, instr_valid, mem_rd_en, mem_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_rd_en !== 1'b1 || mem_addr !== 8'h00) begin
      n_fail++; $display("FAIL async_restart_req: got %b/%h expected 1/00", mem_rd_en, mem_addr);
    end
    lat = 1;
    while (!instr_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++; if (lat != 4 || instr !== exp_instr(8'h00) || instr_pc !== 8'h00) begin
      n_fail++; $display("FAIL async_restart: got lat=%0d %h@%h expected lat=4 %h@00", lat, instr, instr_pc, exp_instr(8'h00));
    end
    fetch_en = 1'b0; instr_ready = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Random consumer, random fetch_en gaps and random redirects against a
  // stream model: consumed instructions follow start, start+2, ...; requests
  // follow start, start+1, ...; fetched-but-unconsumed work never exceeds
  // DEPTH; a stalled head never changes.
  task automatic test_random();
    logic [7:0]  exp_pc, exp_req, redir_tgt;
    logic [15:0] prev_instr;
    logic [7:0]  prev_pc;
    logic        prev_valid, prev_ready, last_redir;
    logic        rdy, fe, rd;
    int          reqs, pops, total;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    do_reset();
    exp_pc = 8'h00; exp_req = 8'h00; redir_tgt = 8'h00;
    reqs = 0; pops = 0; total = 0;
    prev_valid = 1'b0; prev_ready = 1'b0; last_redir = 1'b0;
    prev_instr = '0; prev_pc = '0;
    @(negedge clk);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (last_redir) begin
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_flush: valid=%b expected 0 cycle %0d", instr_valid, cyc); end
        exp_pc = redir_tgt; exp_req = redir_tgt; reqs = 0; pops = 0;
      end else if (prev_valid && !prev_ready) begin
        n_cmp++; if (instr_valid !== 1'b1 || instr !== prev_instr || instr_pc !== prev_pc) begin
          n_fail++; $display("FAIL rnd_hold: got v=%b %h@%h expected 1 %h@%h cycle %0d", instr_valid, instr, instr_pc, prev_instr, prev_pc, cyc);
        end
      end
      if (mem_rd_en) begin
        n_cmp++; if (mem_addr !== exp_req) begin n_fail++; $display("FAIL rnd_req_addr: got %h expected %h cycle %0d", mem_addr, exp_req, cyc); end
        exp_req = exp_req + 8'd1;
        reqs++;
      end
      n_cmp++; if ((reqs + 1) / 2 - pops > DEPTH) begin
        n_fail++; $display("FAIL rnd_depth: got %0d outstanding expected <= %0d cycle %0d", (reqs + 1) / 2 - pops, DEPTH, cyc);
      end
      rdy = ($urandom % 10) < 7;
      fe  = ($urandom % 100) < 85;
      rd  = ($urandom % 25) == 0;
      if (instr_valid && rdy) begin
        n_cmp++; if (instr !== exp_instr(exp_pc) || instr_pc !== exp_pc) begin
          n_fail++; $display("FAIL rnd_data: got %h@%h expected %h@%h cycle %0d", instr, instr_pc, exp_instr(exp_pc), exp_pc, cyc);
        end
        exp_pc = exp_pc + 8'd2;
        pops++; total++;
      end
      prev_valid = instr_valid; prev_instr = instr; prev_pc = instr_pc;
      prev_ready = rdy; last_redir = rd;
      if (rd) redir_tgt = 8'($urandom);
      instr_ready = rdy; fetch_en = fe; redirect_valid = rd; redirect_pc = redir_tgt;
      @(negedge clk);
    end
    redirect_valid = 1'b0; fetch_en = 1'b0; instr_ready = 1'b0;
    n_cmp++; if (total < 100) begin n_fail++; $display("FAIL rnd_progress: got %0d transfers expected >= 100", total); end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b1; fetch_en = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
